// File: rtl/sys_reset_pkg.sv
// Shared types, widths and parameter sanity helpers for the staged system
// reset controller.
package sys_reset_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    localparam int SVC_CNT_W = 16;

    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // True when every parameter is legal and both counter reload values fit
    // in the down-counter.
    function automatic bit params_ok(input int num_req, input int num_stages,
                                     input int hold_cycles, input int stage_gap,
                                     input int cnt_w);
        bit ok;
        ok = in_range(num_req, 2, 8) && in_range(num_stages, 1, 8) &&
             in_range(hold_cycles, 1, 255) && in_range(stage_gap, 1, 255) &&
             in_range(cnt_w, 1, 30);
        if (ok) begin
            ok = ((hold_cycles - 1) < (1 << cnt_w)) && ((stage_gap - 1) < (1 << cnt_w));
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/sys_reset_rr_arb.sv
// Combinational round-robin picker: the first eligible requester at or after
// the pointer wins, wrapping around past NUM_REQ-1.
module sys_reset_rr_arb
    import sys_reset_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    // Scan NUM_REQ positions starting at ptr, keeping the first hit.
    always_comb begin
        logic [IDX_W:0]   sum_s;
        logic [IDX_W-1:0] idx_s;
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(off);
            if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[IDX_W-1:0];
            if (!any_valid && eligible[idx_s]) begin
                any_valid        = 1'b1;
                grant_idx        = idx_s;
                grant_oh[idx_s]  = 1'b1;
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/sys_reset_seq.sv
// Arbitrated, staged system reset controller. One requester is serviced at a
// time; every service pulls all stages low, holds them, then releases them in
// order (stage 0 first) with a fixed gap. The power-on pass behaves like a
// service without ack, counting or pointer advance.
module sys_reset_seq
    import sys_reset_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 15,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_STAGES-1:0]      stage_resetn,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [SVC_CNT_W-1:0]       svc_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0]      HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_STAGES-1:0] STG_ONE   = NUM_STAGES'(1);
    localparam logic [NUM_REQ-1:0]    REQ_ONE   = NUM_REQ'(1);

    if (!params_ok(NUM_REQ, NUM_STAGES, HOLD_CYCLES, STAGE_GAP, CNT_W)) begin : g_param_err
        $error("sys_reset_seq: parameter out of range");
    end

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]  stage_q, stage_d;
    logic [NUM_REQ-1:0]     armed_q, armed_d;
    logic [NUM_REQ-1:0]     pend_q, pend_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic                   por_q, por_d;
    logic [SVC_CNT_W-1:0]   svc_q, svc_d;

    logic [NUM_REQ-1:0]     eligible_s;
    logic [NUM_REQ-1:0]     win_oh_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   win_any_s;
    logic [NUM_STAGES-1:0]  rel_stage_s;

    // Pending bits keep requests raised while busy alive until the next IDLE.
    assign eligible_s  = (req | pend_q) & armed_q;
    // Releasing the next stage shifts one more '1' in from stage 0 upward.
    assign rel_stage_s = (stage_q << 1) | STG_ONE;

    sys_reset_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .eligible  (eligible_s),
        .ptr       (rr_q),
        .grant_oh  (win_oh_s),
        .grant_idx (win_idx_s),
        .any_valid (win_any_s)
    );

    // Next-state, counter, stage and bookkeeping logic of the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        armed_d = armed_q | ~req;
        pend_d  = pend_q | (req & armed_q);
        ack_d   = '0;
        rr_d    = rr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        por_d   = por_q;
        svc_d   = svc_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (win_any_s) begin
                    grant_d = win_idx_s;
                    armed_d = armed_d & ~win_oh_s;
                    pend_d  = pend_d & ~win_oh_s;
                    stage_d = '0;
                    busy_d  = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD, RELEASE: begin
                if (cnt_q == '0) begin
                    stage_d = rel_stage_s;
                    cnt_d   = GAP_LOAD;
                    if (&rel_stage_s) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        por_d   = 1'b0;
                        if (!por_q) begin
                            ack_d = REQ_ONE << grant_q;
                            svc_d = (svc_q == '1) ? svc_q : svc_q + SVC_CNT_W'(1);
                            rr_d  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                        end else begin
                            ack_d = '0;
                        end
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                stage_d = '0;
                busy_d  = 1'b1;
                cnt_d   = HOLD_LOAD;
                state_d = HOLD;
            end
        endcase
    end

    // State and output registers; reset forces every stage low and restarts
    // the power-on pass.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LOAD;
            stage_q <= '0;
            armed_q <= '1;
            pend_q  <= '0;
            ack_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            busy_q  <= 1'b1;
            por_q   <= 1'b1;
            svc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            por_q   <= por_d;
            svc_q   <= svc_d;
        end
    end

    assign ack          = ack_q;
    assign stage_resetn = stage_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;
    assign svc_count    = svc_q;

endmodule

// File: tb/tb_sys_reset_seq.sv
// Scoreboard bench for sys_reset_seq: a default instance (A) and a
// single-stage, one-cycle corner instance (B) share clock and reset.
module tb_sys_reset_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [3:0]  req_a, ack_a;
    logic [2:0]  stg_a;
    logic        busy_a;
    logic [1:0]  gid_a;
    logic [15:0] svc_a;
    logic [1:0]  req_b, ack_b;
    logic [0:0]  stg_b;
    logic        busy_b;
    logic [0:0]  gid_b;
    logic [15:0] svc_b;

    sys_reset_seq #(.NUM_REQ(4), .NUM_STAGES(3), .HOLD_CYCLES(15), .STAGE_GAP(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .resetn(resetn), .req(req_a), .ack(ack_a), .stage_resetn(stg_a),
        .busy(busy_a), .grant_id(gid_a), .svc_count(svc_a));

    sys_reset_seq #(.NUM_REQ(2), .NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .CNT_W(8)) u_dut_b (
        .clk(clk), .resetn(resetn), .req(req_b), .ack(ack_b), .stage_resetn(stg_b),
        .busy(busy_b), .grant_id(gid_b), .svc_count(svc_b));

    typedef struct { int ack; int gid; int svc; int t; int lat; } exp_t;
    typedef struct { int start; bit por; int last_end; int prev; } mst_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    mst_t ma = '{start: 0, por: 1'b1, last_end: -100, prev: 0};
    mst_t mb = '{start: 0, por: 1'b1, last_end: -100, prev: 0};
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   fin_req = 1'b0;
    bit   fin_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sequence-start detection and per-stage low-time checks.
    task automatic mon_stages(input string nm, input int ns, input int h, input int g,
                              input int stg, input int busy_v, inout mst_t m);
        int mask;
        mask = (1 << ns) - 1;
        if (m.por) begin
            m.start = cyc;
            m.por   = 1'b0;
        end else if (m.prev == mask && stg == 0) begin
            chk({nm, " idle gap before sequence"}, int'((cyc - m.last_end) >= 2), 1);
            m.start = cyc;
        end
        for (int k = 0; k < ns; k++) begin
            if (!m.prev[k] && stg[k]) begin
                chk($sformatf("%s stage%0d low cycles", nm, k), cyc - m.start, h + k * g);
                if (k == ns - 1) begin
                    chk({nm, " busy after last release"}, busy_v, 0);
                    m.last_end = cyc;
                end
            end
        end
        m.prev = stg;
    endtask

    task automatic mon_ack(input string nm, input exp_t e, input int ackv, input int gid,
                           input int svc, input int busy_v, input int ack_off, input mst_t m);
        chk({nm, " ack vector"}, ackv, e.ack);
        chk({nm, " grant_id"}, gid, e.gid);
        chk({nm, " svc_count"}, svc, e.svc);
        chk({nm, " busy during ack"}, busy_v, 0);
        chk({nm, " ack cycle from first low"}, cyc - m.start, ack_off);
        if (e.lat != 0) begin
            chk({nm, " ack latency from request"}, cyc - e.t, e.lat);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every ack.
    always @(negedge clk) begin
        if (!resetn) begin
            chk("A reset stage_resetn", int'(stg_a), 0);
            chk("A reset ack", int'(ack_a), 0);
            chk("A reset busy", int'(busy_a), 1);
            chk("A reset grant_id", int'(gid_a), 0);
            chk("A reset svc_count", int'(svc_a), 0);
            chk("B reset stage_resetn", int'(stg_b), 0);
            chk("B reset ack", int'(ack_b), 0);
            ma.por = 1'b1; ma.prev = 0;
            mb.por = 1'b1; mb.prev = 0;
        end else begin
            mon_stages("A", 3, 15, 4, int'(stg_a), int'(busy_a), ma);
            mon_stages("B", 1, 1, 1, int'(stg_b), int'(busy_b), mb);
            if (ack_a != 4'd0) begin
                if (qa.size() == 0) begin
                    chk("A unexpected ack", int'(ack_a), 0);
                end else begin
                    ea = qa.pop_front();
                    mon_ack("A", ea, int'(ack_a), int'(gid_a), int'(svc_a), int'(busy_a), 23, ma);
                end
            end
            if (ack_b != 2'd0) begin
                if (qb.size() == 0) begin
                    chk("B unexpected ack", int'(ack_b), 0);
                end else begin
                    eb = qb.pop_front();
                    mon_ack("B", eb, int'(ack_b), int'(gid_b), int'(svc_b), int'(busy_b), 1, mb);
                end
            end
            if (qa.size() > 0 && (cyc - qa[0].t) > 300) begin
                chk("A ack timeout", 0, 1);
                ea = qa.pop_front();
            end
            if (qb.size() > 0 && (cyc - qb[0].t) > 300) begin
                chk("B ack timeout", 0, 1);
                eb = qb.pop_front();
            end
        end
        if (fin_req && !fin_ack) begin
            chk("A scoreboard drained", qa.size(), 0);
            chk("B scoreboard drained", qb.size(), 0);
            chk("A final svc_count", int'(svc_a), 1);
            fin_ack = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 400 && (qa.size() != 0 || qb.size() != 0); i++) step();
    endtask

    // Stimulus: directed scenarios, each pushing its hand-computed acks.
    initial begin
        resetn = 1'b0;
        req_a  = 4'd0;
        req_b  = 2'd0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (35) step();

        // Corner instance: one stage, 1-cycle hold, request on req[0].
        qb.push_back('{ack: 1, gid: 0, svc: 1, t: cyc, lat: 2});
        req_b = 2'b01;
        step();
        req_b = 2'b00;
        wait_empty();
        repeat (3) step();

        // Contention: 0, 1, 3 serviced in round-robin order.
        qa.push_back('{ack: 1, gid: 0, svc: 1, t: cyc, lat: 24});
        qa.push_back('{ack: 2, gid: 1, svc: 2, t: cyc, lat: 0});
        qa.push_back('{ack: 8, gid: 3, svc: 3, t: cyc, lat: 0});
        req_a = 4'b1011;
        for (int i = 0; i < 200 && req_a != 4'd0; i++) begin
            step();
            req_a = req_a & ~ack_a;
        end
        wait_empty();
        repeat (3) step();

        // Single one-cycle request on req[2].
        qa.push_back('{ack: 4, gid: 2, svc: 4, t: cyc, lat: 24});
        req_a = 4'b0100;
        step();
        req_a = 4'd0;
        wait_empty();
        repeat (3) step();

        // Held level on req[1]: one service only, then re-arm by dropping.
        qa.push_back('{ack: 2, gid: 1, svc: 5, t: cyc, lat: 24});
        req_a = 4'b0010;
        repeat (100) step();
        req_a = 4'd0;
        step();
        qa.push_back('{ack: 2, gid: 1, svc: 6, t: cyc, lat: 24});
        req_a = 4'b0010;
        for (int i = 0; i < 200 && req_a != 4'd0; i++) begin
            step();
            req_a = req_a & ~ack_a;
        end
        wait_empty();
        repeat (3) step();

        // Reset during RELEASE: sequence aborted, req[3] serviced after power-on.
        qa.push_back('{ack: 8, gid: 3, svc: 1, t: cyc, lat: 0});
        req_a = 4'b1000;
        step();
        step();
        for (int i = 0; i < 100 && stg_a[0] !== 1'b1; i++) step();
        step();
        step();
        @(posedge clk);
        #3 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 200 && req_a != 4'd0; i++) begin
            step();
            req_a = req_a & ~ack_a;
        end
        wait_empty();
        repeat (3) step();

        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_ack; i++) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
